// File: rtl/i2c_target_pkg.sv
// Shared definitions for the I2C target memory: FSM state encoding,
// bus ACK/NACK levels and the majority vote used by the optional
// glitch filter (I2C_TARGET_GLITCH_FILTER_EN).
package i2c_target_pkg;

  typedef enum logic [3:0] {
    IDLE,
    DEV_ADDR,
    ACK_DEV,
    WORD_ADDR,
    ACK_WORD,
    WR_DATA,
    ACK_WR,
    RD_DATA,
    RD_ACK,
    IGNORE
  } i2c_state_e;

  // Line levels on SDA during the acknowledge bit
  localparam logic ACK_LEVEL  = 1'b0;
  localparam logic NACK_LEVEL = 1'b1;

  function automatic logic majority3(input logic [2:0] s);
    return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
  endfunction

endpackage

// File: rtl/i2c_line_sync.sv
// Pad-line conditioner: 2-flop synchronizer, optional 3-sample majority
// filter (I2C_TARGET_GLITCH_FILTER_EN, +2 cycles latency), and single-cycle
// rise/fall pulses derived from the conditioned level.
module i2c_line_sync (
  input  logic clk,
  input  logic rst,
  input  logic line,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [1:0] sync_q;
  logic       filt;
  logic       prev_q;

  // Synchronizer, preset high so idle (pulled-up) lines show no edge after reset
  always_ff @(posedge clk) begin
    if (rst) sync_q <= '1;
    else     sync_q <= {sync_q[0], line};
  end

`ifdef I2C_TARGET_GLITCH_FILTER_EN
  import i2c_target_pkg::*;

  logic [2:0] hist_q;
  logic       maj_q;

  // Three-sample history and registered majority vote suppress 1-cycle pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      hist_q <= '1;
      maj_q  <= 1'b1;
    end else begin
      hist_q <= {hist_q[1:0], sync_q[1]};
      maj_q  <= majority3(hist_q);
    end
  end

  assign filt = maj_q;
`else
  assign filt = sync_q[1];
`endif

  // Previous conditioned level for edge detection
  always_ff @(posedge clk) begin
    if (rst) prev_q <= 1'b1;
    else     prev_q <= filt;
  end

  assign level = filt;
  assign rise  = filt & ~prev_q;
  assign fall  = ~filt & prev_q;

endmodule

// File: rtl/i2c_target_mem.sv
// I2C target exposing a byte-addressed memory with an auto-incrementing
// word pointer. Optional SCL/SDA glitch filter: I2C_TARGET_GLITCH_FILTER_EN.
// SDA is open-drain: sda_oe=1 pulls the line low.
module i2c_target_mem
  import i2c_target_pkg::*;
#(
  parameter logic [6:0]  TARGET_ADDR = 7'h50,
  parameter int unsigned MEM_DEPTH   = 256
) (
  input  logic       axi_aclk,
  input  logic       axi_areset,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_oe,
  output logic       busy,
  output logic       wr_strobe,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data
);

  logic scl_lvl, scl_rise, scl_fall;
  logic sda_lvl, sda_rise, sda_fall;
  logic start, stop;

  i2c_line_sync u_scl_sync (
    .clk  (axi_aclk),
    .rst  (axi_areset),
    .line (scl_i),
    .level(scl_lvl),
    .rise (scl_rise),
    .fall (scl_fall)
  );

  i2c_line_sync u_sda_sync (
    .clk  (axi_aclk),
    .rst  (axi_areset),
    .line (sda_i),
    .level(sda_lvl),
    .rise (sda_rise),
    .fall (sda_fall)
  );

  assign start = sda_fall & scl_lvl;
  assign stop  = sda_rise & scl_lvl;

  i2c_state_e state_q, state_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] tx_q, tx_d;
  logic [7:0] ptr_q, ptr_d;
  logic       sda_oe_q, sda_oe_d;
  logic       busy_q, busy_d;
  logic       wr_strobe_q, wr_strobe_d;
  logic [7:0] wr_addr_q, wr_addr_d;
  logic [7:0] wr_data_q, wr_data_d;
  logic       mem_we;
  logic       in_range;
  logic [7:0] rd_data;
  logic       bit_rx, byte_done;

  logic [7:0] mem [MEM_DEPTH];

  assign in_range  = (32'(ptr_q) < MEM_DEPTH);
  assign rd_data   = in_range ? mem[ptr_q] : 8'hFF;
  assign bit_rx    = scl_rise && (bit_cnt_q != 4'd8);
  assign byte_done = scl_fall && (bit_cnt_q == 4'd8);

  // Storage array, written only by completed in-range data bytes; never reset
  always_ff @(posedge axi_aclk) begin
    if (mem_we) mem[ptr_q] <= shift_q;
  end

  // State and datapath registers
  always_ff @(posedge axi_aclk) begin
    if (axi_areset) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      tx_q        <= '0;
      ptr_q       <= '0;
      sda_oe_q    <= 1'b0;
      busy_q      <= 1'b0;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      tx_q        <= tx_d;
      ptr_q       <= ptr_d;
      sda_oe_q    <= sda_oe_d;
      busy_q      <= busy_d;
      wr_strobe_q <= wr_strobe_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
    end
  end

  // Next-state logic: bits shift in on SCL rise, SDA ownership changes on SCL fall
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    tx_d        = tx_q;
    ptr_d       = ptr_q;
    sda_oe_d    = sda_oe_q;
    busy_d      = busy_q;
    wr_strobe_d = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    mem_we      = 1'b0;

    if (start) begin
      state_d   = DEV_ADDR;
      bit_cnt_d = '0;
      sda_oe_d  = 1'b0;
    end else if (stop) begin
      state_d   = IDLE;
      bit_cnt_d = '0;
      sda_oe_d  = 1'b0;
      busy_d    = 1'b0;
    end else begin
      unique case (state_q)
        DEV_ADDR, WORD_ADDR, WR_DATA: begin
          if (bit_rx) begin
            shift_d   = {shift_q[6:0], sda_lvl};
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (byte_done) begin
            bit_cnt_d = '0;
            sda_oe_d  = ~ACK_LEVEL;
            if (state_q == DEV_ADDR) begin
              if (shift_q[7:1] == TARGET_ADDR) begin
                state_d = ACK_DEV;
                busy_d  = 1'b1;
              end else begin
                state_d  = IGNORE;
                sda_oe_d = 1'b0;
                busy_d   = 1'b0;
              end
            end else if (state_q == WORD_ADDR) begin
              state_d = ACK_WORD;
              ptr_d   = shift_q;
            end else begin
              state_d = ACK_WR;
              ptr_d   = ptr_q + 8'd1;
              if (in_range) begin
                mem_we      = 1'b1;
                wr_strobe_d = 1'b1;
                wr_addr_d   = ptr_q;
                wr_data_d   = shift_q;
              end
            end
          end
        end
        ACK_DEV: begin
          if (scl_fall) begin
            bit_cnt_d = '0;
            if (shift_q[0]) begin
              state_d  = RD_DATA;
              tx_d     = {rd_data[6:0], 1'b0};
              sda_oe_d = ~rd_data[7];
            end else begin
              state_d  = WORD_ADDR;
              sda_oe_d = 1'b0;
            end
          end
        end
        ACK_WORD, ACK_WR: begin
          if (scl_fall) begin
            state_d   = WR_DATA;
            bit_cnt_d = '0;
            sda_oe_d  = 1'b0;
          end
        end
        RD_DATA: begin
          if (bit_rx) begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (byte_done) begin
            state_d   = RD_ACK;
            bit_cnt_d = '0;
            sda_oe_d  = 1'b0;
            ptr_d     = ptr_q + 8'd1;
          end else if (scl_fall) begin
            sda_oe_d = ~tx_q[7];
            tx_d     = {tx_q[6:0], 1'b0};
          end
        end
        RD_ACK: begin
          if (scl_rise) begin
            shift_d = {shift_q[6:0], sda_lvl};
          end else if (scl_fall) begin
            bit_cnt_d = '0;
            if (shift_q[0] == NACK_LEVEL) begin
              state_d  = IGNORE;
              sda_oe_d = 1'b0;
              busy_d   = 1'b0;
            end else begin
              state_d  = RD_DATA;
              tx_d     = {rd_data[6:0], 1'b0};
              sda_oe_d = ~rd_data[7];
            end
          end
        end
        IDLE, IGNORE: ;
        default: state_d = IDLE;
      endcase
    end
  end

  assign sda_oe    = sda_oe_q;
  assign busy      = busy_q;
  assign wr_strobe = wr_strobe_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;

endmodule
